// File: rtl/exe_stage_wbq.sv
// RV32 execute stage: p1 register, WB_DEPTH-deep write-back queue with forwarding, branch resolution, LSU loads/stores.
// Optional macro EXE_MISALIGN_CHK_EN adds the misalign output and suppresses misaligned half/word accesses.
module exe_stage_wbq #(
    parameter int XLEN     = 32,
    parameter int WB_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] pc,
    input  logic [11:0]     i_cls,
    input  logic [4:0]      rs1_a,
    input  logic [4:0]      rs2_a_shamt,
    input  logic [4:0]      rd_a,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rf_rs1_o,
    input  logic [XLEN-1:0] rf_rs2_o,
    input  logic            flush0,
    output logic            stall,
    output logic            branch,
    output logic [XLEN-1:0] br_adr_i1,
    output logic [XLEN-1:0] br_adr_i2,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_i1,
    output logic [XLEN-1:0] alu_i2,
    input  logic [XLEN-1:0] alu_o,
    output logic            rf_rd_e,
    output logic [4:0]      rf_rd_a,
    output logic [XLEN-1:0] rf_rd_i,
    output logic [XLEN-1:0] lsu_a,
    output logic [3:0]      lsu_we,
    output logic [XLEN-1:0] lsu_wd,
    output logic [3:0]      lsu_re,
    input  logic            lsu_vld,
    input  logic [XLEN-1:0] lsu_rd
`ifdef EXE_MISALIGN_CHK_EN
    ,
    output logic            misalign
`endif
);
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} ld_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = 4'b0011 << a;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a, input logic [XLEN-1:0] w);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = w >> {a, 3'b000};
        case (f3)
            3'b000:  r = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  r = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b100:  r = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0] p1_pc_r, p1_imm_r, p1_rs1_d_r, p1_rs2_d_r;
    logic [11:0]     p1_cls_r;
    logic [4:0]      p1_rs1_a_r, p1_rs2_a_r, p1_rd_r;
    logic [2:0]      p1_f3_r;
    logic            p1_alt_r;
    ld_state_e       state_r;

    logic            q_we_r   [WB_DEPTH];
    logic [4:0]      q_rd_r   [WB_DEPTH];
    logic [XLEN-1:0] q_data_r [WB_DEPTH];

    logic [XLEN-1:0] fwd1_s, fwd2_s, ld_data_s;
    logic            lui_s, auipc_s, jal_s, jalr_s, b_s, ld_s, st_s, alui_s, alu_s;
    logic            push_s, ld_done_s, mis_s, cond_s;
    logic [3:0]      mask_s;
    logic            unused_s;

    assign lui_s   = p1_cls_r[0];
    assign auipc_s = p1_cls_r[1];
    assign jal_s   = p1_cls_r[2];
    assign jalr_s  = p1_cls_r[3];
    assign b_s     = p1_cls_r[4];
    assign ld_s    = p1_cls_r[5];
    assign st_s    = p1_cls_r[6];
    assign alui_s  = p1_cls_r[7];
    assign alu_s   = p1_cls_r[8];
    assign unused_s = ^{funct7[6], funct7[4:0], p1_cls_r[11:9]};

    assign push_s    = (lui_s | auipc_s | jal_s | jalr_s | alui_s | alu_s) & (p1_rd_r != 5'd0);
    assign ld_done_s = (state_r == S_WAIT) & lsu_vld;
    assign ld_data_s = load_ext(p1_f3_r, lsu_a[1:0], lsu_rd);
    assign mask_s    = lane_mask(p1_f3_r[1:0], alu_o[1:0]);

`ifdef EXE_MISALIGN_CHK_EN
    assign mis_s = (ld_s | st_s) & (((p1_f3_r[1:0] == 2'b01) & alu_o[0]) |
                                    ((p1_f3_r[1:0] == 2'b10) & (alu_o[1:0] != 2'b00)));
`else
    assign mis_s = 1'b0;
`endif

    // In WAIT the stall follows lsu_vld so the cycle that returns data also advances the pipe.
    assign stall = (state_r == S_WAIT) ? ~lsu_vld : (ld_s & ~mis_s);

    assign rf_rd_e = q_we_r[WB_DEPTH-1] & ~stall;
    assign rf_rd_a = q_rd_r[WB_DEPTH-1];
    assign rf_rd_i = q_data_r[WB_DEPTH-1];

    // Operand forwarding: scan oldest to youngest so entry 0 wins.
    always_comb begin
        fwd1_s = p1_rs1_d_r;
        fwd2_s = p1_rs2_d_r;
        for (int i = WB_DEPTH - 1; i >= 0; i--) begin
            if (q_we_r[i] && (q_rd_r[i] == p1_rs1_a_r)) fwd1_s = q_data_r[i];
            else fwd1_s = fwd1_s;
            if (q_we_r[i] && (q_rd_r[i] == p1_rs2_a_r)) fwd2_s = q_data_r[i];
            else fwd2_s = fwd2_s;
        end
    end

    // ALU operand and opcode selection.
    always_comb begin
        alu_op[2:0] = (lui_s | auipc_s | jal_s | jalr_s | ld_s | st_s) ? 3'b000 : p1_f3_r;
        alu_op[3]   = (alu_s | (alui_s & (p1_f3_r == 3'b101))) ? p1_alt_r : 1'b0;
        alu_i1      = lui_s ? {XLEN{1'b0}} : ((auipc_s | jal_s | jalr_s) ? p1_pc_r : fwd1_s);
        if (lui_s | auipc_s | ld_s | st_s)            alu_i2 = p1_imm_r;
        else if (jal_s | jalr_s)                      alu_i2 = {{(XLEN-3){1'b0}}, 3'd4};
        else if (alui_s & (p1_f3_r[1:0] == 2'b01))    alu_i2 = {{(XLEN-5){1'b0}}, p1_rs2_a_r};
        else if (alui_s)                              alu_i2 = p1_imm_r;
        else                                          alu_i2 = fwd2_s;
    end

    // Branch condition and target adder operands.
    always_comb begin
        case (p1_f3_r)
            3'b000:  cond_s = (fwd1_s == fwd2_s);
            3'b001:  cond_s = (fwd1_s != fwd2_s);
            3'b100:  cond_s = ($signed(fwd1_s) <  $signed(fwd2_s));
            3'b101:  cond_s = ($signed(fwd1_s) >= $signed(fwd2_s));
            3'b110:  cond_s = (fwd1_s <  fwd2_s);
            3'b111:  cond_s = (fwd1_s >= fwd2_s);
            default: cond_s = 1'b0;
        endcase
        branch    = jal_s | jalr_s | (b_s & cond_s);
        br_adr_i1 = jalr_s ? fwd1_s : p1_pc_r;
        br_adr_i2 = p1_imm_r;
    end

    // p1 pipeline register; flush0 kills the class bits even while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1_cls_r   <= 12'd0;
            p1_pc_r    <= {XLEN{1'b0}};
            p1_imm_r   <= {XLEN{1'b0}};
            p1_rs1_d_r <= {XLEN{1'b0}};
            p1_rs2_d_r <= {XLEN{1'b0}};
            p1_rs1_a_r <= 5'd0;
            p1_rs2_a_r <= 5'd0;
            p1_rd_r    <= 5'd0;
            p1_f3_r    <= 3'd0;
            p1_alt_r   <= 1'b0;
        end else begin
            if (flush0)      p1_cls_r <= 12'd0;
            else if (!stall) p1_cls_r <= i_cls;
            if (!stall) begin
                p1_pc_r    <= pc;
                p1_imm_r   <= imm;
                p1_rs1_d_r <= rf_rs1_o;
                p1_rs2_d_r <= rf_rs2_o;
                p1_rs1_a_r <= rs1_a;
                p1_rs2_a_r <= rs2_a_shamt;
                p1_rd_r    <= rd_a;
                p1_f3_r    <= funct3;
                p1_alt_r   <= funct7[5];
            end
        end
    end

    // Write-back queue: shifts whenever the pipe advances, entry 0 takes ALU or load result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                q_we_r[i]   <= 1'b0;
                q_rd_r[i]   <= 5'd0;
                q_data_r[i] <= {XLEN{1'b0}};
            end
        end else if (!stall) begin
            q_we_r[0]   <= ld_done_s ? (p1_rd_r != 5'd0) : push_s;
            q_rd_r[0]   <= p1_rd_r;
            q_data_r[0] <= ld_done_s ? ld_data_s : alu_o;
            for (int i = 1; i < WB_DEPTH; i++) begin
                q_we_r[i]   <= q_we_r[i-1];
                q_rd_r[i]   <= q_rd_r[i-1];
                q_data_r[i] <= q_data_r[i-1];
            end
        end
    end

    // Load FSM and LSU request registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
            lsu_a   <= {XLEN{1'b0}};
            lsu_we  <= 4'b0000;
            lsu_wd  <= {XLEN{1'b0}};
            lsu_re  <= 4'b0000;
`ifdef EXE_MISALIGN_CHK_EN
            misalign <= 1'b0;
`endif
        end else begin
            lsu_we <= 4'b0000;
`ifdef EXE_MISALIGN_CHK_EN
            misalign <= (state_r == S_IDLE) & mis_s;
`endif
            case (state_r)
                S_IDLE: begin
                    if (st_s) begin
                        lsu_a  <= alu_o;
                        lsu_wd <= store_data(p1_f3_r[1:0], fwd2_s);
                        lsu_we <= mis_s ? 4'b0000 : mask_s;
                    end else if (ld_s && !mis_s) begin
                        lsu_a   <= alu_o;
                        lsu_re  <= mask_s;
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lsu_vld) begin
                        lsu_re  <= 4'b0000;
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_stage_wbq.sv
// Directed self-checking bench for exe_stage_wbq with a behavioural external ALU.
module tb_exe_stage_wbq;
    localparam logic [11:0] C_LUI = 12'h001, C_JAL = 12'h004, C_JALR = 12'h008, C_B = 12'h010;
    localparam logic [11:0] C_LD = 12'h020, C_ST = 12'h040, C_ALUI = 12'h080, C_ALU = 12'h100;

    logic        clk, rstn, flush0, stall, branch, rf_rd_e, lsu_vld;
    logic [31:0] pc, imm, rf_rs1_o, rf_rs2_o, br_adr_i1, br_adr_i2, alu_i1, alu_i2, alu_o;
    logic [31:0] rf_rd_i, lsu_a, lsu_wd, lsu_rd;
    logic [11:0] i_cls;
    logic [4:0]  rs1_a, rs2_a_shamt, rd_a, rf_rd_a;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [3:0]  alu_op, lsu_we, lsu_re;
`ifdef EXE_MISALIGN_CHK_EN
    logic        misalign;
`endif
    int n_checks, n_errors;

    exe_stage_wbq #(.XLEN(32), .WB_DEPTH(3)) dut (
        .clk(clk), .rstn(rstn), .pc(pc), .i_cls(i_cls), .rs1_a(rs1_a), .rs2_a_shamt(rs2_a_shamt),
        .rd_a(rd_a), .funct3(funct3), .funct7(funct7), .imm(imm), .rf_rs1_o(rf_rs1_o),
        .rf_rs2_o(rf_rs2_o), .flush0(flush0), .stall(stall), .branch(branch),
        .br_adr_i1(br_adr_i1), .br_adr_i2(br_adr_i2), .alu_op(alu_op), .alu_i1(alu_i1),
        .alu_i2(alu_i2), .alu_o(alu_o), .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a), .rf_rd_i(rf_rd_i),
        .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd), .lsu_re(lsu_re), .lsu_vld(lsu_vld),
        .lsu_rd(lsu_rd)
`ifdef EXE_MISALIGN_CHK_EN
        , .misalign(misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model.
    always_comb begin
        case (alu_op[2:0])
            3'b000:  alu_o = alu_op[3] ? alu_i1 - alu_i2 : alu_i1 + alu_i2;
            3'b001:  alu_o = alu_i1 << alu_i2[4:0];
            3'b010:  alu_o = ($signed(alu_i1) < $signed(alu_i2)) ? 32'd1 : 32'd0;
            3'b011:  alu_o = (alu_i1 < alu_i2) ? 32'd1 : 32'd0;
            3'b100:  alu_o = alu_i1 ^ alu_i2;
            3'b101:  alu_o = alu_op[3] ? 32'($signed(alu_i1) >>> alu_i2[4:0]) : alu_i1 >> alu_i2[4:0];
            3'b110:  alu_o = alu_i1 | alu_i2;
            default: alu_o = alu_i1 & alu_i2;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [11:0] c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im, input logic [31:0] p,
                       input logic [31:0] d1, input logic [31:0] d2);
        i_cls = c; rs1_a = r1; rs2_a_shamt = r2; rd_a = rd; funct3 = f3; funct7 = f7;
        imm = im; pc = p; rf_rs1_o = d1; rf_rs2_o = d2;
    endtask

    task automatic bubble();
        drv(12'h000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush0 = 1'b0; lsu_vld = 1'b0; lsu_rd = 32'd0;
        bubble();
        step(); step();
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
        n_checks++; if (rf_rd_e !== 1'b0) begin n_errors++; $display("FAIL rst_rf_rd_e: got %b exp 0", rf_rd_e); end
        n_checks++; if ({lsu_we, lsu_re} !== 8'h00) begin n_errors++; $display("FAIL rst_lsu_en: got %h exp 00", {lsu_we, lsu_re}); end
        n_checks++; if (lsu_a !== 32'd0) begin n_errors++; $display("FAIL rst_lsu_a: got %h exp 0", lsu_a); end
        n_checks++; if (branch !== 1'b0) begin n_errors++; $display("FAIL rst_branch: got %b exp 0", branch); end
        rstn = 1'b1;
    endtask

    task automatic test_fwd();
        drv(C_ALUI, 5'd0, 5'd0, 5'd1, 3'b000, 7'd0, 32'd5, 32'h0, 32'd0, 32'd0);
        step();
        n_checks++; if (alu_i2 !== 32'd5) begin n_errors++; $display("FAIL addi_i2: got %h exp 5", alu_i2); end
        drv(C_ALU, 5'd1, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 32'h4, 32'hDEAD0000, 32'hDEAD0000);
        step();
        n_checks++; if (alu_i1 !== 32'd5) begin n_errors++; $display("FAIL fwd1_e0: got %h exp 5", alu_i1); end
        n_checks++; if (alu_i2 !== 32'd5) begin n_errors++; $display("FAIL fwd2_e0: got %h exp 5", alu_i2); end
        bubble();
        step();
        n_checks++; if (rf_rd_e !== 1'b0) begin n_errors++; $display("FAIL wb_early: got %b exp 0", rf_rd_e); end
        step();
        n_checks++; if ({rf_rd_e, rf_rd_a, rf_rd_i} !== {1'b1, 5'd1, 32'd5}) begin n_errors++; $display("FAIL wb_x1: got %b %0d %h exp 1 1 5", rf_rd_e, rf_rd_a, rf_rd_i); end
        step();
        n_checks++; if ({rf_rd_e, rf_rd_a, rf_rd_i} !== {1'b1, 5'd2, 32'd10}) begin n_errors++; $display("FAIL wb_x2: got %b %0d %h exp 1 2 a", rf_rd_e, rf_rd_a, rf_rd_i); end
    endtask

    task automatic test_alu_ops();
        drv(C_ALUI, 5'd20, 5'd4, 5'd0, 3'b101, 7'h20, 32'h00000404, 32'h8, 32'h80000000, 32'd0);
        step();
        n_checks++; if (alu_op !== 4'hD) begin n_errors++; $display("FAIL srai_op: got %h exp d", alu_op); end
        n_checks++; if (alu_i2 !== 32'd4) begin n_errors++; $display("FAIL srai_shamt: got %h exp 4", alu_i2); end
        drv(C_ALU, 5'd22, 5'd23, 5'd0, 3'b000, 7'h20, 32'd0, 32'hC, 32'd10, 32'd3);
        step();
        n_checks++; if ({alu_op, alu_o} !== {4'h8, 32'd7}) begin n_errors++; $display("FAIL sub: got %h %h exp 8 7", alu_op, alu_o); end
        drv(C_LUI, 5'd0, 5'd0, 5'd0, 3'b111, 7'h7F, 32'h12345000, 32'h10, 32'hFFFFFFFF, 32'd0);
        step();
        n_checks++; if ({alu_op, alu_i1, alu_i2} !== {4'h0, 32'd0, 32'h12345000}) begin n_errors++; $display("FAIL lui: got %h %h %h exp 0 0 12345000", alu_op, alu_i1, alu_i2); end
        bubble();
        step();
    endtask

    task automatic test_branch();
        drv(C_B, 5'd5, 5'd6, 5'd0, 3'b100, 7'd0, 32'h10, 32'h200, 32'hFFFFFFFF, 32'd1);
        step();
        n_checks++; if ({branch, br_adr_i1, br_adr_i2} !== {1'b1, 32'h200, 32'h10}) begin n_errors++; $display("FAIL blt: got %b %h %h exp 1 200 10", branch, br_adr_i1, br_adr_i2); end
        drv(C_B, 5'd5, 5'd6, 5'd0, 3'b110, 7'd0, 32'h10, 32'h204, 32'hFFFFFFFF, 32'd1);
        step();
        n_checks++; if (branch !== 1'b0) begin n_errors++; $display("FAIL bltu: got %b exp 0", branch); end
        drv(C_B, 5'd5, 5'd6, 5'd0, 3'b010, 7'd0, 32'h10, 32'h208, 32'd1, 32'd1);
        step();
        n_checks++; if (branch !== 1'b0) begin n_errors++; $display("FAIL b_f3_010: got %b exp 0", branch); end
        drv(C_B, 5'd5, 5'd6, 5'd0, 3'b111, 7'd0, 32'h10, 32'h20C, 32'hFFFFFFFF, 32'd1);
        step();
        n_checks++; if (branch !== 1'b1) begin n_errors++; $display("FAIL bgeu: got %b exp 1", branch); end
        drv(C_JALR, 5'd21, 5'd0, 5'd0, 3'b000, 7'd0, 32'h8, 32'h210, 32'h4001, 32'd0);
        step();
        n_checks++; if ({branch, br_adr_i1, alu_i1, alu_i2} !== {1'b1, 32'h4001, 32'h210, 32'd4}) begin n_errors++; $display("FAIL jalr: got %b %h %h %h exp 1 4001 210 4", branch, br_adr_i1, alu_i1, alu_i2); end
        bubble();
        step();
    endtask

    task automatic test_store();
        drv(C_ST, 5'd7, 5'd8, 5'd0, 3'b000, 7'd0, 32'd3, 32'h300, 32'h1000, 32'h000000AB);
        step();
        n_checks++; if (lsu_we !== 4'b0000) begin n_errors++; $display("FAIL sb_early: got %b exp 0000", lsu_we); end
        drv(C_ST, 5'd7, 5'd8, 5'd0, 3'b001, 7'd0, 32'd2, 32'h304, 32'h1000, 32'h1234BEEF);
        step();
        n_checks++; if ({lsu_a, lsu_we, lsu_wd} !== {32'h1003, 4'b1000, 32'hABABABAB}) begin n_errors++; $display("FAIL sb: got %h %b %h exp 1003 1000 abababab", lsu_a, lsu_we, lsu_wd); end
        drv(C_ST, 5'd7, 5'd8, 5'd0, 3'b010, 7'd0, 32'd4, 32'h308, 32'h1000, 32'hCAFEF00D);
        step();
        n_checks++; if ({lsu_a, lsu_we, lsu_wd} !== {32'h1002, 4'b1100, 32'hBEEFBEEF}) begin n_errors++; $display("FAIL sh: got %h %b %h exp 1002 1100 beefbeef", lsu_a, lsu_we, lsu_wd); end
        bubble();
        step();
        n_checks++; if ({lsu_a, lsu_we, lsu_wd} !== {32'h1004, 4'b1111, 32'hCAFEF00D}) begin n_errors++; $display("FAIL sw: got %h %b %h exp 1004 1111 cafef00d", lsu_a, lsu_we, lsu_wd); end
        step();
        n_checks++; if ({lsu_a, lsu_we} !== {32'h1004, 4'b0000}) begin n_errors++; $display("FAIL st_pulse: got %h %b exp 1004 0000", lsu_a, lsu_we); end
        drv(C_ST, 5'd7, 5'd8, 5'd0, 3'b001, 7'd0, 32'd3, 32'h30C, 32'h1000, 32'h00007788);
        step();
        bubble();
        step();
`ifdef EXE_MISALIGN_CHK_EN
        n_checks++; if ({misalign, lsu_we} !== {1'b1, 4'b0000}) begin n_errors++; $display("FAIL sh_mis: got %b %b exp 1 0000", misalign, lsu_we); end
`else
        n_checks++; if ({lsu_we, lsu_wd} !== {4'b1000, 32'h77887788}) begin n_errors++; $display("FAIL sh_trunc: got %b %h exp 1000 77887788", lsu_we, lsu_wd); end
`endif
        step();
    endtask

    task automatic test_load();
        drv(C_ALUI, 5'd0, 5'd0, 5'd12, 3'b000, 7'd0, 32'd12, 32'h400, 32'd0, 32'd0);
        step();
        drv(C_ALUI, 5'd0, 5'd0, 5'd13, 3'b000, 7'd0, 32'd13, 32'h404, 32'd0, 32'd0);
        step();
        drv(C_ALUI, 5'd0, 5'd0, 5'd14, 3'b000, 7'd0, 32'd14, 32'h408, 32'd0, 32'd0);
        step();
        drv(C_LD, 5'd10, 5'd0, 5'd9, 3'b001, 7'd0, 32'd2, 32'h40C, 32'h2000, 32'd0);
        step();
        n_checks++; if ({stall, rf_rd_e, lsu_re} !== {1'b1, 1'b0, 4'b0000}) begin n_errors++; $display("FAIL lh_c1: got %b %b %b exp 1 0 0000", stall, rf_rd_e, lsu_re); end
        drv(C_ALU, 5'd9, 5'd9, 5'd11, 3'b000, 7'd0, 32'd0, 32'h410, 32'h5A5A5A5A, 32'h5A5A5A5A);
        step();
        n_checks++; if ({stall, lsu_re, lsu_a} !== {1'b1, 4'b1100, 32'h2002}) begin n_errors++; $display("FAIL lh_req: got %b %b %h exp 1 1100 2002", stall, lsu_re, lsu_a); end
        step();
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lh_c3: got %b exp 1", stall); end
        step();
        n_checks++; if ({stall, lsu_re} !== {1'b1, 4'b1100}) begin n_errors++; $display("FAIL lh_c4: got %b %b exp 1 1100", stall, lsu_re); end
        step();
        lsu_vld = 1'b1; lsu_rd = 32'h80015555;
        #1;
        n_checks++; if ({stall, rf_rd_e, rf_rd_a, rf_rd_i} !== {1'b0, 1'b1, 5'd12, 32'd12}) begin n_errors++; $display("FAIL lh_vld: got %b %b %0d %h exp 0 1 12 c", stall, rf_rd_e, rf_rd_a, rf_rd_i); end
        step();
        lsu_vld = 1'b0; lsu_rd = 32'd0;
        #1;
        n_checks++; if ({lsu_re, alu_i1, alu_i2} !== {4'b0000, 32'hFFFF8001, 32'hFFFF8001}) begin n_errors++; $display("FAIL lh_fwd: got %b %h %h exp 0000 ffff8001 ffff8001", lsu_re, alu_i1, alu_i2); end
        n_checks++; if (rf_rd_a !== 5'd13) begin n_errors++; $display("FAIL lh_wb13: got %0d exp 13", rf_rd_a); end
        bubble();
        step(); step();
        n_checks++; if ({rf_rd_e, rf_rd_a, rf_rd_i} !== {1'b1, 5'd9, 32'hFFFF8001}) begin n_errors++; $display("FAIL lh_wb: got %b %0d %h exp 1 9 ffff8001", rf_rd_e, rf_rd_a, rf_rd_i); end
        step();
        n_checks++; if ({rf_rd_a, rf_rd_i} !== {5'd11, 32'hFFFF0002}) begin n_errors++; $display("FAIL add_wb: got %0d %h exp 11 ffff0002", rf_rd_a, rf_rd_i); end
        drv(C_LD, 5'd10, 5'd0, 5'd16, 3'b100, 7'd0, 32'd0, 32'h420, 32'h2003, 32'd0);
        step();
        drv(C_ALU, 5'd16, 5'd0, 5'd15, 3'b000, 7'd0, 32'd0, 32'h424, 32'hDEADBEEF, 32'd0);
        step();
        lsu_vld = 1'b1; lsu_rd = 32'h9A000000;
        #1;
        n_checks++; if ({stall, lsu_re} !== {1'b0, 4'b1000}) begin n_errors++; $display("FAIL lbu_vld: got %b %b exp 0 1000", stall, lsu_re); end
        step();
        lsu_vld = 1'b0; lsu_rd = 32'd0;
        bubble();
        #1;
        n_checks++; if ({alu_i1, alu_i2} !== {32'h0000009A, 32'd0}) begin n_errors++; $display("FAIL lbu_fwd: got %h %h exp 9a 0", alu_i1, alu_i2); end
        step();
    endtask

    task automatic test_reset_mid_load();
        drv(C_LD, 5'd10, 5'd0, 5'd17, 3'b010, 7'd0, 32'd0, 32'h500, 32'h3000, 32'd0);
        step();
        bubble();
        step();
        n_checks++; if ({stall, lsu_re} !== {1'b1, 4'b1111}) begin n_errors++; $display("FAIL lw_wait: got %b %b exp 1 1111", stall, lsu_re); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if ({stall, rf_rd_e, lsu_re} !== {1'b0, 1'b0, 4'b0000}) begin n_errors++; $display("FAIL rst_mid: got %b %b %b exp 0 0 0000", stall, rf_rd_e, lsu_re); end
        #1;
        rstn = 1'b1;
        lsu_vld = 1'b1; lsu_rd = 32'hFFFFFFFF;
        step();
        lsu_vld = 1'b0;
        n_checks++; if ({stall, lsu_re} !== {1'b0, 4'b0000}) begin n_errors++; $display("FAIL late_vld: got %b %b exp 0 0000", stall, lsu_re); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (rf_rd_e !== 1'b0) begin n_errors++; $display("FAIL late_vld_wb%0d: got %b exp 0", k, rf_rd_e); end
        end
    endtask

    task automatic test_flush();
        drv(C_JAL, 5'd0, 5'd0, 5'd5, 3'b000, 7'd0, 32'h40, 32'h100, 32'd0, 32'd0);
        step();
        n_checks++; if ({branch, br_adr_i1, br_adr_i2, alu_i1, alu_i2} !== {1'b1, 32'h100, 32'h40, 32'h100, 32'd4}) begin n_errors++; $display("FAIL jal: got %b %h %h %h %h exp 1 100 40 100 4", branch, br_adr_i1, br_adr_i2, alu_i1, alu_i2); end
        drv(C_JAL, 5'd0, 5'd0, 5'd6, 3'b000, 7'd0, 32'h40, 32'h140, 32'd0, 32'd0);
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        bubble();
        #1;
        n_checks++; if (branch !== 1'b0) begin n_errors++; $display("FAIL flush_branch: got %b exp 0", branch); end
        step(); step();
        n_checks++; if ({rf_rd_e, rf_rd_a, rf_rd_i} !== {1'b1, 5'd5, 32'h104}) begin n_errors++; $display("FAIL jal_wb: got %b %0d %h exp 1 5 104", rf_rd_e, rf_rd_a, rf_rd_i); end
        step();
        n_checks++; if (rf_rd_e !== 1'b0) begin n_errors++; $display("FAIL flush_wb: got %b exp 0", rf_rd_e); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_fwd();
        test_alu_ops();
        test_branch();
        test_store();
        test_load();
        test_reset_mid_load();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
